// File: rtl/rf_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter_if
// Bundles every non-clock/reset signal of the register-file writeback arbiter.
//   Requester A (ALU writeback)  : a_valid, a_ready, a_regsel[2:0], a_data
//   Requester B (load writeback) : b_valid, b_ready, b_regsel[2:0], b_data
//   Register-file write port     : write, writeregsel[2:0], writedata
//   Read-port snoop              : read1regsel, read2regsel -> read1busy, read2busy
//   Protocol status              : err (sticky)
// modport slave  : seen by the arbiter.
// modport master : seen by the requesters / register file side (the bench).
// ---------------------------------------------------------------------------
interface rf_wb_arbiter_if #(
  parameter int WIDTH = 16
) ();
  logic             a_valid;
  logic             a_ready;
  logic [2:0]       a_regsel;
  logic [WIDTH-1:0] a_data;

  logic             b_valid;
  logic             b_ready;
  logic [2:0]       b_regsel;
  logic [WIDTH-1:0] b_data;

  logic             write;
  logic [2:0]       writeregsel;
  logic [WIDTH-1:0] writedata;

  logic [2:0]       read1regsel;
  logic [2:0]       read2regsel;
  logic             read1busy;
  logic             read2busy;

  logic             err;

  modport slave (
    input  a_valid, a_regsel, a_data,
    input  b_valid, b_regsel, b_data,
    input  read1regsel, read2regsel,
    output a_ready, b_ready,
    output write, writeregsel, writedata,
    output read1busy, read2busy,
    output err
  );

  modport master (
    output a_valid, a_regsel, a_data,
    output b_valid, b_regsel, b_data,
    output read1regsel, read2regsel,
    input  a_ready, b_ready,
    input  write, writeregsel, writedata,
    input  read1busy, read2busy,
    input  err
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Round-robin arbiter merging two writeback requesters (A = ALU, B = load)
// onto the single write port of an 8 x WIDTH register file.
// Ports:
//   clk  - single clock, all state on the rising edge
//   rst  - synchronous, active-low reset
//   bus  - rf_wb_arbiter_if.slave: both requester handshakes, the registered
//          register-file write port, read-select snoop with busy flags, and
//          a sticky handshake-violation flag (err).
// Behaviour summary:
//   - ready is combinational; when both requesters are valid the one named by
//     the round-robin pointer wins, and the pointer flips to the other side
//     after every acceptance.
//   - An accepted transfer appears on the write port one cycle later; back to
//     back acceptances give one write per cycle.
//   - A requester that was stalled must present the same request next cycle;
//     otherwise err is set and stays set until reset.
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  rf_wb_arbiter_if.slave    bus
);

  // Requester index 0 = A, 1 = B; the pointer holds the index that wins a tie.
  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  logic [1:0]             req_valid;
  logic [1:0][2:0]        req_sel;
  logic [1:0][WIDTH-1:0]  req_data;
  logic [1:0]             req_ready;
  logic [1:0]             req_viol;

  logic [1:0][2:0]        rd_sel;
  logic [1:0]             rd_busy;

  logic                   ptr_q, ptr_d;
  logic                   write_q, write_d;
  logic [2:0]             wsel_q, wsel_d;
  logic [WIDTH-1:0]       wdata_q, wdata_d;
  logic                   err_q, err_d;

  assign req_valid[0] = bus.a_valid;
  assign req_sel[0]   = bus.a_regsel;
  assign req_data[0]  = bus.a_data;
  assign req_valid[1] = bus.b_valid;
  assign req_sel[1]   = bus.b_regsel;
  assign req_data[1]  = bus.b_data;

  assign rd_sel[0] = bus.read1regsel;
  assign rd_sel[1] = bus.read2regsel;

  genvar gi;

  // Per-requester grant and stall tracking.
  for (gi = 0; gi < 2; gi++) begin : g_req
    logic             stall_q, stall_d;
    logic [2:0]       stall_sel_q, stall_sel_d;
    logic [WIDTH-1:0] stall_data_q, stall_data_d;

    // A requester is ready if it is valid and either the other side is idle
    // or the pointer names it. Reset masks ready so nothing is accepted.
    assign req_ready[gi] = rst & req_valid[gi] &
                           (~req_valid[1-gi] | (ptr_q == 1'(gi)));

    // Capture the request only while it is actually waiting; regsel/data are
    // don't-care otherwise.
    always_comb begin
      stall_d      = req_valid[gi] & ~req_ready[gi];
      stall_sel_d  = stall_sel_q;
      stall_data_d = stall_data_q;
      if (stall_d) begin
        stall_sel_d  = req_sel[gi];
        stall_data_d = req_data[gi];
      end
    end

    // A stalled request must be held unchanged until it is accepted.
    assign req_viol[gi] = stall_q & (~req_valid[gi] |
                                     (req_sel[gi]  != stall_sel_q) |
                                     (req_data[gi] != stall_data_q));

    always_ff @(posedge clk) begin
      if (!rst) begin
        stall_q      <= 1'b0;
        stall_sel_q  <= '0;
        stall_data_q <= '0;
      end else begin
        stall_q      <= stall_d;
        stall_sel_q  <= stall_sel_d;
        stall_data_q <= stall_data_d;
      end
    end
  end

  // Hazard snoop: a register is busy while any valid request targets it or
  // the write currently on the port targets it.
  for (gi = 0; gi < 2; gi++) begin : g_busy
    assign rd_busy[gi] = rst & (
                           (req_valid[0] & (req_sel[0] == rd_sel[gi])) |
                           (req_valid[1] & (req_sel[1] == rd_sel[gi])) |
                           (write_q      & (wsel_q     == rd_sel[gi])));
  end

  // Next-state logic. The ready terms are mutually exclusive, so at most one
  // acceptance happens per cycle.
  always_comb begin
    ptr_d   = ptr_q;
    write_d = 1'b0;
    wsel_d  = wsel_q;
    wdata_d = wdata_q;
    err_d   = err_q | (|req_viol);
    if (req_ready[0]) begin
      ptr_d   = PTR_B;
      write_d = 1'b1;
      wsel_d  = req_sel[0];
      wdata_d = req_data[0];
    end else if (req_ready[1]) begin
      ptr_d   = PTR_A;
      write_d = 1'b1;
      wsel_d  = req_sel[1];
      wdata_d = req_data[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q   <= PTR_A;
      write_q <= 1'b0;
      wsel_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      write_q <= write_d;
      wsel_q  <= wsel_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.a_ready     = req_ready[0];
  assign bus.b_ready     = req_ready[1];
  assign bus.write       = write_q;
  assign bus.writeregsel = wsel_q;
  assign bus.writedata   = wdata_q;
  assign bus.read1busy   = rd_busy[0];
  assign bus.read2busy   = rd_busy[1];
  assign bus.err         = err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Directed scenarios followed by randomized traffic for rf_wb_arbiter. Every
// cycle the observable outputs are compared with a behavioural model of the
// arbitration rules. Inputs change on the falling edge, outputs are sampled
// shortly afterwards, and the rising edge in between advances the DUT.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

  localparam int WIDTH = 16;

  logic clk;
  logic rst;

  rf_wb_arbiter_if #(.WIDTH(WIDTH)) bus ();

  rf_wb_arbiter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Behavioural model: whose turn it is on a tie, what the write port shows,
  // whether err has been raised, and the request each side left waiting.
  int               m_turn;     // 0 = A has priority on a tie, 1 = B
  bit               m_write;
  int               m_wsel;
  int               m_wdata;
  bit               m_err;
  bit               m_wait[2];
  int               m_wait_sel[2];
  int               m_wait_data[2];
  bit               m_ready[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit reg_busy(input int sel);
    bit b;
    b = 1'b0;
    if (bus.a_valid && int'(bus.a_regsel) == sel) b = 1'b1;
    if (bus.b_valid && int'(bus.b_regsel) == sel) b = 1'b1;
    if (m_write && m_wsel == sel) b = 1'b1;
    return rst && b;
  endfunction

  task automatic model_reset();
    m_turn  = 0;
    m_write = 1'b0;
    m_wsel  = 0;
    m_wdata = 0;
    m_err   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_wait[i]      = 1'b0;
      m_wait_sel[i]  = 0;
      m_wait_data[i] = 0;
    end
  endtask

  // Check one cycle against the model, advance the model, move to next cycle.
  task automatic cycle();
    bit v[2];
    int s[2];
    int d[2];
    #1;
    v[0] = bus.a_valid; s[0] = int'(bus.a_regsel); d[0] = int'(bus.a_data);
    v[1] = bus.b_valid; s[1] = int'(bus.b_regsel); d[1] = int'(bus.b_data);
    for (int i = 0; i < 2; i++)
      m_ready[i] = rst && v[i] && (!v[1-i] || m_turn == i);

    check("a_ready",     bus.a_ready,     m_ready[0]);
    check("b_ready",     bus.b_ready,     m_ready[1]);
    check("read1busy",   bus.read1busy,   reg_busy(int'(bus.read1regsel)));
    check("read2busy",   bus.read2busy,   reg_busy(int'(bus.read2regsel)));
    check("write",       bus.write,       m_write);
    check("writeregsel", bus.writeregsel, m_wsel);
    check("writedata",   bus.writedata,   m_wdata);
    check("err",         bus.err,         m_err);

    if (!rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_wait[i] && (!v[i] || s[i] != m_wait_sel[i] || d[i] != m_wait_data[i]))
          m_err = 1'b1;
        m_wait[i]      = v[i] && !m_ready[i];
        m_wait_sel[i]  = s[i];
        m_wait_data[i] = d[i];
      end
      m_write = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (m_ready[i]) begin
          m_turn  = 1 - i;
          m_write = 1'b1;
          m_wsel  = s[i];
          m_wdata = d[i];
          $display("[TB] cyc %0d grant %s reg %0d data %04h", cyc, (i == 0) ? "A" : "B", s[i], d[i]);
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.a_valid = 1'b0; bus.a_regsel = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_regsel = '0; bus.b_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    idle();
    bus.read1regsel = '0;
    bus.read2regsel = '0;
    model_reset();
    @(negedge clk);

    // Reset holds ready low even with requests present.
    bus.a_valid = 1'b1; bus.a_regsel = 3'd2; bus.b_valid = 1'b1; bus.b_regsel = 3'd2;
    bus.read1regsel = 3'd2;
    #1;
    check("rst_a_ready", bus.a_ready, 1'b0);
    check("rst_busy",    bus.read1busy, 1'b0);
    cycle();
    do_reset();

    // Single request: accepted in one cycle, written in the next.
    bus.a_valid = 1'b1; bus.a_regsel = 3'd3; bus.a_data = 16'h1234;
    #1 check("single_ready", bus.a_ready, 1'b1);
    cycle();
    idle();
    #1;
    check("single_write", bus.write, 1'b1);
    check("single_sel",   bus.writeregsel, 3'd3);
    check("single_data",  bus.writedata, 16'h1234);
    cycle();
    #1 check("single_drop", bus.write, 1'b0);
    cycle();

    // Alternation from reset release: grants A,B,A,B with no idle writes.
    do_reset();
    bus.a_valid = 1'b1; bus.a_regsel = 3'd1; bus.a_data = 16'h0001;
    bus.b_valid = 1'b1; bus.b_regsel = 3'd2; bus.b_data = 16'h0002;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("alt_a_ready", bus.a_ready, (k % 2) == 0);
      check("alt_b_ready", bus.b_ready, (k % 2) == 1);
      if (k > 0) begin
        check("alt_write", bus.write, 1'b1);
        check("alt_sel",   bus.writeregsel, ((k % 2) == 1) ? 3'd1 : 3'd2);
      end
      cycle();
    end
    idle();
    #1 check("alt_last_sel", bus.writeregsel, 3'd2);
    cycle();

    // Hazard: B waits on reg4 behind A; read1 snoops reg4.
    do_reset();
    bus.read1regsel = 3'd4;
    bus.a_valid = 1'b1; bus.a_regsel = 3'd0; bus.a_data = 16'h0BAD;
    bus.b_valid = 1'b1; bus.b_regsel = 3'd4; bus.b_data = 16'h4444;
    #1 check("haz_stall_busy", bus.read1busy, 1'b1);
    cycle();
    bus.a_valid = 1'b0;
    #1 check("haz_grant_busy", bus.read1busy, 1'b1);
    cycle();
    bus.b_valid = 1'b0;
    #1;
    check("haz_write_sel", bus.writeregsel, 3'd4);
    check("haz_write_busy", bus.read1busy, 1'b1);
    cycle();
    #1 check("haz_clear_busy", bus.read1busy, 1'b0);
    cycle();

    // Protocol error: stalled B changes its data.
    do_reset();
    bus.a_valid = 1'b1; bus.a_regsel = 3'd0; bus.a_data = 16'h1111;
    bus.b_valid = 1'b1; bus.b_regsel = 3'd1; bus.b_data = 16'h00FF;
    cycle();
    bus.a_valid = 1'b0; bus.b_data = 16'h0F0F;
    #1 check("perr_not_yet", bus.err, 1'b0);
    cycle();
    idle();
    for (int k = 0; k < 3; k++) begin
      #1 check("perr_sticky", bus.err, 1'b1);
      cycle();
    end
    rst = 1'b0;
    #1 check("perr_rst_cycle", bus.err, 1'b1);
    cycle();
    rst = 1'b1;
    #1 check("perr_cleared", bus.err, 1'b0);
    cycle();

    // Same-register collision: A then B both land on reg5.
    do_reset();
    bus.a_valid = 1'b1; bus.a_regsel = 3'd5; bus.a_data = 16'hAAAA;
    bus.b_valid = 1'b1; bus.b_regsel = 3'd5; bus.b_data = 16'h5555;
    cycle();
    bus.a_valid = 1'b0;
    #1 check("coll_first", bus.writedata, 16'hAAAA);
    cycle();
    bus.b_valid = 1'b0;
    #1;
    check("coll_second", bus.writedata, 16'h5555);
    check("coll_sel",    bus.writeregsel, 3'd5);
    cycle();

    // Mid-operation reset: ptr left at B and err set, then reset with requests.
    bus.a_valid = 1'b1; bus.a_regsel = 3'd6; bus.a_data = 16'h6666;
    bus.b_valid = 1'b1; bus.b_regsel = 3'd7; bus.b_data = 16'h7777;
    cycle();                       // A granted, B waits, ptr -> B
    bus.b_valid = 1'b0;            // waiting B withdraws: err
    cycle();
    bus.b_valid = 1'b1;
    rst = 1'b0;
    #1;
    check("mid_a_ready", bus.a_ready, 1'b0);
    check("mid_b_ready", bus.b_ready, 1'b0);
    cycle();
    rst = 1'b1;
    #1;
    check("mid_write", bus.write, 1'b0);
    check("mid_err",   bus.err, 1'b0);
    check("mid_ptr_a", bus.a_ready, 1'b1);
    cycle();
    idle();
    cycle();

    // Randomized traffic, occasional protocol violations and resets.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 39) != 0);
      bus.read1regsel = 3'($urandom_range(0, 7));
      bus.read2regsel = 3'($urandom_range(0, 7));
      if (!(m_wait[0] && $urandom_range(0, 49) != 0)) begin
        bus.a_valid  = ($urandom_range(0, 2) != 0);
        bus.a_regsel = 3'($urandom_range(0, 7));
        bus.a_data   = 16'($urandom);
      end
      if (!(m_wait[1] && $urandom_range(0, 49) != 0)) begin
        bus.b_valid  = ($urandom_range(0, 2) != 0);
        bus.b_regsel = 3'($urandom_range(0, 7));
        bus.b_data   = 16'($urandom);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 16, data width of the register-file write port.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: a_valid in 1, a_ready out 1, a_regsel in 3, a_data in WIDTH; requester A (ALU writeback).
REQ-005 SHALL have ports: b_valid in 1, b_ready out 1, b_regsel in 3, b_data in WIDTH; requester B (load writeback).
REQ-006 SHALL have ports: write out 1, writeregsel out 3, writedata out WIDTH; registered, driving the 8x WIDTH register-file write port.
REQ-007 SHALL have ports: read1regsel in 3, read2regsel in 3; register-file read selects to snoop.
REQ-008 SHALL have ports: read1busy out 1, read2busy out 1; pending-write hazard flags.
REQ-009 SHALL have port: err out 1; sticky handshake-protocol violation flag.

Function
REQ-010 SHALL treat a transfer as accepted when x_valid & x_ready are both high at a rising edge; at most one transfer SHALL be accepted per cycle.
REQ-011 SHALL keep a round-robin pointer ptr in {A,B}; ready is combinational: a_ready = a_valid & (!b_valid | ptr==A); b_ready = b_valid & (!a_valid | ptr==B).
REQ-012 SHALL set ptr to B after an A acceptance, to A after a B acceptance, and hold ptr when nothing is accepted.
REQ-013 SHALL, in the cycle after an acceptance, drive write=1 with writeregsel/writedata equal to the accepted regsel/data (latency 1 cycle).
REQ-014 SHALL drive write=0 in any cycle not following an acceptance; writeregsel/writedata SHALL then hold their last values.
REQ-015 SHALL sustain one write per cycle under continuous requests (no bubbles).
REQ-016 SHALL resolve both requesters targeting the same register by ptr order; both writes SHALL issue, in consecutive cycles, so the later grant's data remains in the register.
REQ-017 SHALL drive readNbusy = (a_valid & a_regsel==readNregsel) | (b_valid & b_regsel==readNregsel) | (write & writeregsel==readNregsel), combinationally, for N=1,2.
REQ-018 SHALL register, for each requester, whether it was stalled (valid & !ready) together with its regsel and data.
REQ-019 SHALL set err at the next edge when a requester stalled in the previous cycle presents, in the current cycle, valid=0 or a different regsel or data.
REQ-020 SHALL keep err high once set, until reset.
REQ-021 SHALL ignore x_regsel/x_data while x_valid=0.

Reset
REQ-022 SHALL, at any rising edge with rst=0, set write=0, writeregsel=0, writedata=0, ptr=A, err=0, and clear both stall records, regardless of in-flight state.
REQ-023 SHALL force a_ready=b_ready=0 and read1busy=read2busy=0 while rst=0; no transfer SHALL be accepted in a reset cycle.
REQ-024 SHALL not issue any write before the first acceptance following reset release.

Verification
REQ-025 SHALL verify a single request: after reset, a_valid=1, a_regsel=3, a_data=0x1234 for one cycle -> a_ready=1 that cycle; next cycle write=1, writeregsel=3, writedata=0x1234; following cycle write=0.
REQ-026 SHALL verify alternation: a (reg1, 0x0001) and b (reg2, 0x0002) held valid from reset release -> grants A,B,A,B; write sequence reg1,reg2,reg1,reg2 with no idle cycles.
REQ-027 SHALL verify a hazard: b_valid=1 reg4 stalled behind A, read1regsel=4 -> read1busy=1 while stalled and during b's write cycle, then 0 in the cycle after write drops.
REQ-028 SHALL verify a protocol error: b stalled with data 0x00FF, next cycle b_data=0x0F0F -> err=1 at the following edge, and err stays 1 until rst=0.
REQ-029 SHALL verify a same-register collision: ptr=A, a (reg5, 0xAAAA) and b (reg5, 0x5555) together -> writes 0xAAAA then 0x5555 to reg5.
REQ-030 SHALL verify mid-operation reset: rst=0 in the cycle an acceptance occurs -> next cycle write=0, err=0, ptr=A, ready outputs 0 during reset.
